// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// core-wide default PC constants and the latency-counter helpers.
package fetch_pkg;

  // Fetch FSM state encoding
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  // Defaults shared with the rest of the core
  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam int unsigned DEFAULT_PC_STEP  = 4;

  // Latency counter is sized for the largest supported memory latency (15)
  localparam int unsigned LAT_CNT_W       = 4;
  localparam int unsigned MAX_MEM_LATENCY = 15;

  // Counter preload so that read data is sampled MEM_LATENCY cycles after the strobe
  function automatic logic [LAT_CNT_W-1:0] lat_preload(input int unsigned lat);
    return LAT_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Fetch-issue tick generator: one-CLK-wide pulse every 2^SLOW cycles.
// SLOW=0 gives a constant-high tick, which is how bench builds run.
module tick_gen #(
  parameter int unsigned SLOW = 0
) (
  input  logic CLK,
  input  logic RESETN,
  output logic tick
);

  localparam int unsigned CW = (SLOW == 0) ? 1 : SLOW;

  logic [CW-1:0] r_cnt;

  // Free-running down-counter; the pulse fires on terminal count
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_cnt <= '1;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = (SLOW == 0) ? 1'b1 : (r_cnt == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer. Issues one read per instruction, waits the
// memory latency, then holds the word for decode until it is accepted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | idle at pc; strobe a read when the issue tick is high
// S_WAIT  | read in flight; down-count until the data is due, then latch
// S_HOLD  | instr_valid high; word held until instr_ready
//
// A redirect beats everything: it loads the new pc, drops whatever word is
// held or in flight, and suppresses the strobe for that cycle.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH              = 32,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [ADDR_WIDTH-1:0] PC_STEP       = ADDR_WIDTH'(DEFAULT_PC_STEP),
  parameter int unsigned MEM_LATENCY             = 1,
  parameter int unsigned TICK_SLOW               = 0
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_preload(MEM_LATENCY);

  fetch_state_t          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [LAT_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [DATA_WIDTH-1:0] r_instr, w_instr_nxt;
  logic [ADDR_WIDTH-1:0] r_instr_pc, w_instr_pc_nxt;
  logic                  w_rstrb;
  logic                  w_tick;
  logic                  w_en_eff;

  tick_gen #(
    .SLOW (TICK_SLOW)
  ) u_tick_gen (
    .CLK    (CLK),
    .RESETN (RESETN),
    .tick   (w_tick)
  );

  // The hardware tick qualifies the external enable; with TICK_SLOW=0 it is transparent
  assign w_en_eff = en & w_tick;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_valid    <= w_valid_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
    end
  end

  // Next-state, datapath updates and the read strobe
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_cnt_nxt      = r_cnt;
    w_valid_nxt    = r_valid;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_rstrb        = 1'b0;

    if (redirect_valid) begin
      // Also covers redirect coinciding with a handshake: the word is consumed
      // and the redirect target wins over pc+PC_STEP.
      w_pc_nxt    = redirect_pc;
      w_valid_nxt = 1'b0;
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_en_eff) begin
            w_rstrb     = 1'b1;
            w_cnt_nxt   = LAT_LOAD;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            w_instr_nxt    = mem_rdata;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            w_state_nxt    = S_HOLD;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            w_valid_nxt = 1'b0;
            w_pc_nxt    = r_pc + PC_STEP;
            w_state_nxt = S_FETCH;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  assign mem_addr    = r_pc;
  assign mem_rstrb   = w_rstrb;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (32-bit / latency 1 and
// 8-bit / latency 3) share stimulus; each has its own memory and a
// transaction-level reference model.
module tb_fetch_sequencer;

  logic        clk, rstn, en, rdy, redir;
  logic [31:0] rpc;
  logic [31:0] rdata0, rdata1;
  logic [31:0] addr0, instr0, ipc0;
  logic        strb0, valid0;
  logic [7:0]  addr1, ipc1;
  logic [31:0] instr1;
  logic        strb1, valid1;

  int n_checks, n_errors, cyc;

  fetch_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(32'h4), .MEM_LATENCY(1)
  ) u_dut0 (
    .CLK(clk), .RESETN(rstn), .en(en),
    .mem_addr(addr0), .mem_rstrb(strb0), .mem_rdata(rdata0),
    .redirect_valid(redir), .redirect_pc(rpc),
    .instr_valid(valid0), .instr(instr0), .instr_pc(ipc0), .instr_ready(rdy)
  );

  fetch_sequencer #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(8'h0), .PC_STEP(8'h4), .MEM_LATENCY(3)
  ) u_dut1 (
    .CLK(clk), .RESETN(rstn), .en(en),
    .mem_addr(addr1), .mem_rstrb(strb1), .mem_rdata(rdata1),
    .redirect_valid(redir), .redirect_pc(rpc[7:0]),
    .instr_valid(valid1), .instr(instr1), .instr_pc(ipc1), .instr_ready(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc[2], m_instr[2], m_ipc[2];
  bit          m_busy[2], m_valid[2];
  int          m_issue[2];
  // Memory: remembers the last strobe so data appears exactly at its due cycle
  bit          s_pend[2];
  int          s_cyc[2];
  logic [31:0] s_addr[2];
  // Values sampled from the DUTs in the last cycle
  bit          ob_strb[2], ob_valid[2];
  logic [31:0] ob_addr[2], ob_instr[2], ob_ipc[2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  function automatic logic [31:0] mem_out(input int k);
    if (s_pend[k] && cyc == s_cyc[k] + lat_of(k)) return word(s_addr[k]);
    return 32'hBAD0_0000 ^ cyc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_busy[k] = 0; m_valid[k] = 0;
      m_instr[k] = 32'h0; m_ipc[k] = 32'h0;
    end
  endtask

  task automatic model_step(input int k, input bit a_en, input bit a_rdy,
                            input bit a_redir, input logic [31:0] a_rpc);
    if (a_redir) begin
      m_pc[k] = a_rpc & mask_of(k); m_busy[k] = 0; m_valid[k] = 0;
    end else if (m_valid[k]) begin
      if (a_rdy) begin
        m_valid[k] = 0; m_pc[k] = (m_pc[k] + 32'd4) & mask_of(k);
      end
    end else if (m_busy[k]) begin
      if (cyc == m_issue[k] + lat_of(k)) begin
        m_valid[k] = 1; m_instr[k] = word(m_pc[k]); m_ipc[k] = m_pc[k]; m_busy[k] = 0;
      end
    end else if (a_en) begin
      m_busy[k] = 1; m_issue[k] = cyc;
    end
  endtask

  // One clock cycle: drive at negedge, sample/compare before posedge, advance model at posedge
  task automatic cycle(input bit a_en, input bit a_rdy, input bit a_redir, input logic [31:0] a_rpc);
    bit e_strb;
    en = a_en; rdy = a_rdy; redir = a_redir; rpc = a_rpc;
    rdata0 = mem_out(0);
    rdata1 = mem_out(1);
    if (!rstn) model_reset();
    #1;
    ob_strb[0] = strb0; ob_addr[0] = addr0; ob_valid[0] = valid0; ob_instr[0] = instr0; ob_ipc[0] = ipc0;
    ob_strb[1] = strb1; ob_addr[1] = {24'h0, addr1}; ob_valid[1] = valid1; ob_instr[1] = instr1;
    ob_ipc[1] = {24'h0, ipc1};
    for (int k = 0; k < 2; k++) begin
      e_strb = !m_busy[k] && !m_valid[k] && a_en && !a_redir;
      chk($sformatf("mem_addr[%0d]", k), ob_addr[k], m_pc[k]);
      chk($sformatf("mem_rstrb[%0d]", k), 32'(ob_strb[k]), 32'(e_strb));
      chk($sformatf("instr_valid[%0d]", k), 32'(ob_valid[k]), 32'(m_valid[k]));
      if (m_valid[k]) begin
        chk($sformatf("instr[%0d]", k), ob_instr[k], m_instr[k]);
        chk($sformatf("instr_pc[%0d]", k), ob_ipc[k], m_ipc[k]);
      end
    end
    @(posedge clk);
    if (rstn) begin
      for (int k = 0; k < 2; k++) model_step(k, a_en, a_rdy, a_redir, a_rpc);
    end
    for (int k = 0; k < 2; k++) begin
      if (ob_strb[k]) begin
        s_pend[k] = 1; s_cyc[k] = cyc; s_addr[k] = ob_addr[k];
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle(0, 0, 0, 32'h0);
    rstn = 1'b1;
  endtask

  task automatic run_to_strobe(input int k, input bit a_rdy, input int bound,
                               output logic [31:0] a, output bit ok);
    ok = 0; a = 32'hX;
    for (int i = 0; i < bound; i++) begin
      cycle(1, a_rdy, 0, 32'h0);
      if (ob_strb[k]) begin
        a = ob_addr[k]; ok = 1;
        return;
      end
    end
  endtask

  task automatic run_to_valid(input int k, input bit a_rdy, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      cycle(1, a_rdy, 0, 32'h0);
      if (ob_valid[k]) begin
        ok = 1;
        return;
      end
    end
  endtask

  typedef struct {
    bit          en, rdy, redir;
    logic [31:0] rpc;
    bit          e_strb;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr, e_ipc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] a;
    bit ok, seen_strb;
    int t_s, t_v;

    // Free run, latency 1: strobes at 0,4,8 every 3 cycles; words 0x100.. at pc 0,4,8
    tbl[0] = '{1, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0,   32'h0};
    tbl[1] = '{1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0,   32'h0};
    tbl[2] = '{1, 1, 0, 32'h0, 0, 32'h0, 1, 32'h100, 32'h0};
    tbl[3] = '{1, 1, 0, 32'h0, 1, 32'h4, 0, 32'h0,   32'h0};
    tbl[4] = '{1, 1, 0, 32'h0, 0, 32'h4, 0, 32'h0,   32'h0};
    tbl[5] = '{1, 1, 0, 32'h0, 0, 32'h4, 1, 32'h101, 32'h4};
    tbl[6] = '{1, 1, 0, 32'h0, 1, 32'h8, 0, 32'h0,   32'h0};
    tbl[7] = '{1, 1, 0, 32'h0, 0, 32'h8, 0, 32'h0,   32'h0};
    tbl[8] = '{1, 1, 0, 32'h0, 0, 32'h8, 1, 32'h102, 32'h8};

    n_checks = 0; n_errors = 0; cyc = 0;
    en = 0; rdy = 0; redir = 0; rpc = 0; rdata0 = 0; rdata1 = 0;
    for (int k = 0; k < 2; k++) s_pend[k] = 0;
    model_reset();
    rstn = 1'b0;
    @(negedge clk);

    do_reset();
    chk("reset_instr0", ob_instr[0], 32'h0);
    chk("reset_ipc0", ob_ipc[0], 32'h0);
    chk("reset_instr1", ob_instr[1], 32'h0);
    chk("reset_ipc1", ob_ipc[1], 32'h0);

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].en, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      chk($sformatf("tbl%0d_strb", i), 32'(ob_strb[0]), 32'(tbl[i].e_strb));
      chk($sformatf("tbl%0d_addr", i), ob_addr[0], tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(ob_valid[0]), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_instr", i), ob_instr[0], tbl[i].e_instr);
        chk($sformatf("tbl%0d_ipc", i), ob_ipc[0], tbl[i].e_ipc);
      end
    end

    // Latency 3: instr_valid rises 4 cycles after the strobe, with the strobed word
    do_reset();
    run_to_strobe(1, 1, 10, a, ok);
    if (!ok) timeout("lat_strobe");
    t_s = cyc - 1;
    run_to_valid(1, 1, 20, ok);
    if (!ok) timeout("lat_valid");
    else begin
      t_v = cyc - 1;
      chk("lat_strobe_to_valid", 32'(t_v - t_s), 32'd4);
      chk("lat_word", ob_instr[1], word(a));
    end

    // Backpressure at pc=8 on the latency-1 instance
    do_reset();
    for (int i = 0; i < 3; i++) run_to_strobe(0, 1, 10, a, ok);
    if (!ok) timeout("bp_strobe");
    else chk("bp_strobe_at_8", a, 32'h8);
    run_to_valid(0, 0, 10, ok);
    if (!ok) timeout("bp_valid");
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 32'h0);
      chk("bp_valid_held", 32'(ob_valid[0]), 32'd1);
      chk("bp_instr_held", ob_instr[0], 32'h102);
      chk("bp_ipc_held", ob_ipc[0], 32'h8);
      chk("bp_no_strobe", 32'(ob_strb[0]), 32'd0);
    end
    run_to_strobe(0, 1, 10, a, ok);
    if (!ok) timeout("bp_release");
    else chk("bp_next_strobe", a, 32'hC);

    // Redirect during S_WAIT on the latency-3 instance
    do_reset();
    cycle(1, 1, 0, 32'h0);
    chk("rw_first_strobe", 32'(ob_strb[1]), 32'd1);
    cycle(1, 1, 1, 32'h40);
    seen_strb = 0; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle(1, 1, 0, 32'h0);
      if (ob_strb[1] && !seen_strb) begin
        seen_strb = 1;
        chk("rw_strobe_addr", ob_addr[1], 32'h40);
      end
      if (ob_valid[1]) begin
        ok = 1;
        chk("rw_ipc", ob_ipc[1], 32'h40);
        chk("rw_instr", ob_instr[1], 32'h110);
      end
    end
    if (!ok) timeout("rw_valid");

    // Redirect together with a handshake in S_HOLD
    do_reset();
    cycle(0, 0, 1, 32'h10);
    run_to_valid(0, 0, 10, ok);
    if (!ok) timeout("rh_valid");
    else chk("rh_ipc", ob_ipc[0], 32'h10);
    cycle(1, 1, 1, 32'h80);
    run_to_strobe(0, 1, 10, a, ok);
    if (!ok) timeout("rh_strobe");
    else chk("rh_strobe_addr", a, 32'h80);

    // PC wrap on the 8-bit instance
    do_reset();
    cycle(0, 0, 1, 32'hFC);
    run_to_valid(1, 0, 20, ok);
    if (!ok) timeout("wrap_valid");
    else begin
      chk("wrap_ipc", ob_ipc[1], 32'hFC);
      chk("wrap_instr", ob_instr[1], 32'h13F);
    end
    cycle(1, 1, 0, 32'h0);
    run_to_strobe(1, 1, 10, a, ok);
    if (!ok) timeout("wrap_strobe");
    else chk("wrap_strobe_addr", a, 32'h0);

    // Reset asserted while a read is in flight
    do_reset();
    cycle(0, 0, 1, 32'h20);
    cycle(1, 1, 0, 32'h0);
    chk("rst_mid_strobe", 32'(ob_strb[1]), 32'd1);
    cycle(1, 1, 0, 32'h0);
    rstn = 1'b0;
    cycle(0, 0, 0, 32'h0);
    chk("rst_mid_addr", ob_addr[1], 32'h0);
    chk("rst_mid_valid", 32'(ob_valid[1]), 32'd0);
    chk("rst_mid_strb", 32'(ob_strb[1]), 32'd0);
    rstn = 1'b1;
    run_to_valid(1, 1, 20, ok);
    if (!ok) timeout("rst_restart");
    else begin
      chk("rst_restart_ipc", ob_ipc[1], 32'h0);
      chk("rst_restart_instr", ob_instr[1], 32'h100);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(3) != 0, $urandom_range(9) < 6, $urandom_range(99) < 8,
              32'($urandom_range(255)) << 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised instruction-fetch sequencer for the RISC-V core; drives the on-chip memory read port and hands fetched words to the decode stage over a valid/ready handshake.
- Generalises the fixed two-state fetch/wait loop with:
  - configurable address/data width, reset vector, PC stride and memory read latency;
  - a clock-enable tick in place of a divided clock;
  - PC redirect (branch/jump) with in-flight discard.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, width of memory read data / instruction.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, increment applied to PC after each consumed instruction.
- MEM_LATENCY, 1, cycles from strobe to valid mem_rdata; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESETN  in  1  reset; asynchronous assert, active-low.
- en  in  1  fetch-issue enable (tick); gates new fetches only.
- mem_addr  out  ADDR_WIDTH  read address; equals current PC.
- mem_rstrb  out  1  read strobe; one-cycle pulse per fetch.
- mem_rdata  in  DATA_WIDTH  read data; valid MEM_LATENCY cycles after strobe.
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  ADDR_WIDTH  target PC.
- instr_valid  out  1  fetched instruction available.
- instr  out  DATA_WIDTH  fetched word; stable while instr_valid=1.
- instr_pc  out  ADDR_WIDTH  address of instr.
- instr_ready  in  1  consumer accepts instr.

Behaviour:
- Reset (RESETN=0, asynchronous):
  - state=S_FETCH, pc=RESET_PC, wait counter=0;
  - instr_valid=0, instr=0, instr_pc=0, mem_rstrb=0.
- mem_addr = pc at all times. mem_rstrb = (state==S_FETCH) & en & ~redirect_valid.
- S_FETCH:
  - en=0: remain, no strobe.
  - en=1: strobe at pc, counter<=MEM_LATENCY-1, go S_WAIT.
- S_WAIT:
  - counter>0: decrement.
  - counter==0: instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, go S_HOLD.
  - Data sampled exactly MEM_LATENCY cycles after the strobe cycle.
- S_HOLD:
  - instr_valid=1; instr/instr_pc held stable.
  - instr_ready=1: instr_valid<=0, pc<=pc+PC_STEP, go S_FETCH.
- Timing: strobe to instr_valid high is MEM_LATENCY+1 cycles. Best-case throughput is one instruction per MEM_LATENCY+2 cycles.
- PC arithmetic: unsigned, modulo 2^ADDR_WIDTH. Wrap from max to 0 is silent and legal.
- Redirect (redirect_valid=1) takes priority in any state:
  - pc<=redirect_pc, instr_valid<=0, state<=S_FETCH;
  - any in-flight read is discarded (data ignored);
  - no strobe is issued in the redirect cycle.
- Simultaneous redirect + handshake in S_HOLD: the instruction counts as consumed; pc takes redirect_pc, not pc+PC_STEP.
- en only affects S_FETCH. A fetch already issued completes even if en drops.
- Reset mid-operation: immediate return to reset values; a pending read is abandoned.
- No output changes while in S_HOLD with instr_ready=0, however long the stall.

Decomposition:
- Shared package fetch_pkg:
  - state encoding localparams S_FETCH=2'd0, S_WAIT=2'd1, S_HOLD=2'd2;
  - default RESET_PC and PC_STEP constants, shared with the core.
- One natural sub-module, tick_gen:
  - parameter SLOW; produces a one-CLK-wide pulse every 2^SLOW cycles to drive en on hardware;
  - tied high in bench builds;
  - same CLK/RESETN.

Test Plan:
- Reset + free run: RESET_PC=0, PC_STEP=4, MEM_LATENCY=1, en=1, instr_ready=1, memory word n = n+0x100 -> strobes at 0,4,8 every 3 cycles; instr=0x100,0x101,0x102 with instr_pc=0,4,8.
- Latency sweep: MEM_LATENCY=3 -> instr_valid rises 4 cycles after each strobe; instr equals the word at the strobed address, never a stale word.
- Backpressure: hold instr_ready=0 for 10 cycles at pc=8 -> instr_valid stays 1, instr/instr_pc constant, no strobe; after release next strobe at 12.
- Redirect mid-wait: MEM_LATENCY=3, redirect_pc=0x40 during S_WAIT -> in-flight data dropped, instr_valid never asserted for the old pc, next strobe at 0x40, then instr_pc=0x40.
- Redirect with handshake: redirect_valid and instr_ready both 1 in S_HOLD at pc=0x10, redirect_pc=0x80 -> next strobe at 0x80, not 0x14.
- Wrap and reset: ADDR_WIDTH=8, pc=0xFC, PC_STEP=4 -> next fetch at 0x00. Assert RESETN=0 mid-S_WAIT -> outputs cleared immediately, restart at RESET_PC.
